// File: rtl/pll_lock_sequencer.sv
// rtl/pll_lock_sequencer.sv - PLL reset pulse, lock qualification and downstream reset release sequencer
module pll_lock_sequencer #(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       sys_reset,
    output logic       ready,
    output logic [7:0] lock_lost_count,
    output logic [7:0] timeout_count,
    output logic [1:0] state
);

    localparam int CYC_MAX = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ? RST_PULSE_CYCLES
                                                                       : LOCK_TIMEOUT_CYCLES;
    localparam int CYC_W = $clog2(CYC_MAX + 1);
    localparam int STB_W = $clog2(LOCK_STABLE_CYCLES + 1);

    localparam logic [CYC_W-1:0] RST_LAST = CYC_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CYC_W-1:0] TMO_LAST = CYC_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [STB_W-1:0] STB_DONE = STB_W'(LOCK_STABLE_CYCLES);

    typedef enum logic [1:0] {
        ST_PLL_RESET = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_RUN       = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             sync_meta;
    logic             locked_s;
    logic [CYC_W-1:0] cyc_q;
    logic [CYC_W-1:0] cyc_d;
    logic [STB_W-1:0] stab_q;
    logic [STB_W-1:0] stab_d;
    logic             lost_inc;
    logic             tmo_inc;

    // pll_locked comes from the PLL's own clock domain; nothing else may look at it.
    always_ff @(posedge refclk) begin
        if (rst) begin
            sync_meta <= 1'b0;
            locked_s  <= 1'b0;
        end else begin
            sync_meta <= pll_locked;
            locked_s  <= sync_meta;
        end
    end

    always_comb begin
        state_d  = state_q;
        stab_d   = stab_q;
        cyc_d    = '0;
        lost_inc = 1'b0;
        tmo_inc  = 1'b0;

        case (state_q)
            ST_PLL_RESET: begin
                if (cyc_q == RST_LAST) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                stab_d = locked_s ? stab_q + 1'b1 : '0;
                // Stable completion takes priority over a timeout landing on the same cycle.
                if (stab_q == STB_DONE) begin
                    state_d = ST_RUN;
                end else if (cyc_q == TMO_LAST) begin
                    state_d = ST_PLL_RESET;
                    tmo_inc = 1'b1;
                end
            end
            ST_RUN: begin
                if (!locked_s) begin
                    state_d  = ST_PLL_RESET;
                    lost_inc = 1'b1;
                end else if (relock_req) begin
                    state_d = ST_PLL_RESET;
                end
            end
            default: state_d = ST_PLL_RESET;
        endcase

        if (state_d != state_q) begin
            cyc_d  = '0;
            stab_d = '0;
        end else if (state_q != ST_RUN) begin
            cyc_d = cyc_q + 1'b1;
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q         <= ST_PLL_RESET;
            cyc_q           <= '0;
            stab_q          <= '0;
            pll_rst         <= 1'b1;
            sys_reset       <= 1'b1;
            ready           <= 1'b0;
            lock_lost_count <= 8'd0;
            timeout_count   <= 8'd0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            stab_q    <= stab_d;
            pll_rst   <= (state_d == ST_PLL_RESET);
            sys_reset <= (state_d != ST_RUN);
            ready     <= (state_d == ST_RUN);
            if (lost_inc && lock_lost_count != 8'hFF) lock_lost_count <= lock_lost_count + 8'd1;
            if (tmo_inc && timeout_count != 8'hFF) timeout_count <= timeout_count + 8'd1;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb/tb_pll_lock_sequencer.sv - directed self-checking bench for pll_lock_sequencer
module tb_pll_lock_sequencer;

    logic       refclk;
    logic       rst;
    logic       pll_locked;
    logic       relock_req;
    logic       pll_rst;
    logic       sys_reset;
    logic       ready;
    logic [7:0] lock_lost_count;
    logic [7:0] timeout_count;
    logic [1:0] state;

    int n_tests = 0;
    int n_fail  = 0;

    pll_lock_sequencer #(
        .RST_PULSE_CYCLES   (4),
        .LOCK_STABLE_CYCLES (8),
        .LOCK_TIMEOUT_CYCLES(32)
    ) dut (
        .refclk         (refclk),
        .rst            (rst),
        .pll_locked     (pll_locked),
        .relock_req     (relock_req),
        .pll_rst        (pll_rst),
        .sys_reset      (sys_reset),
        .ready          (ready),
        .lock_lost_count(lock_lost_count),
        .timeout_count  (timeout_count),
        .state          (state)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget, output int n);
        n = 0;
        while (state !== s && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_ready(input int budget, output int n);
        n = 0;
        while (ready !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, state, 0);
        check({tag, "_pll_rst"}, pll_rst, 1);
        check({tag, "_sys_reset"}, sys_reset, 1);
        check({tag, "_ready"}, ready, 0);
        check({tag, "_lost"}, lock_lost_count, 0);
        check({tag, "_tmo"}, timeout_count, 0);
    endtask

    initial begin
        int n;
        int exp_lost;

        rst        = 1'b1;
        pll_locked = 1'b0;
        relock_req = 1'b0;
        repeat (3) tick();
        check_reset_values("reset");

        // Power-up: reset pulse, then lock held high from WAIT_LOCK entry.
        rst = 1'b0;
        n   = 0;
        do begin
            tick();
            n++;
        end while (pll_rst && n < 20);
        check("rst_pulse_len", n, 4);
        check("wait_entry_state", state, 1);
        pll_locked = 1'b1;
        tick();
        n = 0;
        do begin
            tick();
            n++;
        end while (!ready && n < 40);
        check("lock_latency", n, 10);
        check("run_sys_reset", sys_reset, 0);
        check("run_state", state, 2);
        check("run_lost", lock_lost_count, 0);
        check("run_tmo", timeout_count, 0);

        // Lock loss in RUN.
        pll_locked = 1'b0;
        repeat (3) tick();
        check("loss_ready", ready, 0);
        check("loss_sys_reset", sys_reset, 1);
        check("loss_state", state, 0);
        check("loss_count", lock_lost_count, 1);
        pll_locked = 1'b1;
        wait_ready(40, n);
        check("relock_ready", ready, 1);
        check("relock_state", state, 2);

        // Software relock in RUN, then ignored in WAIT_LOCK.
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        check("swrelock_state", state, 0);
        check("swrelock_pll_rst", pll_rst, 1);
        check("swrelock_lost", lock_lost_count, 1);
        n = 0;
        do begin
            tick();
            n++;
        end while (pll_rst && n < 20);
        check("swrelock_pulse_len", n, 4);
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        check("relock_ignored_wait", state, 1);
        wait_ready(40, n);
        check("swrelock_run", state, 2);
        check("swrelock_lost_after", lock_lost_count, 1);
        check("swrelock_tmo_after", timeout_count, 0);

        // One-cycle glitch after 5 stable cycles restarts qualification.
        pll_locked = 1'b0;
        wait_state(2'd1, 40, n);
        check("glitch_enter_wait", state, 1);
        pll_locked = 1'b1;
        repeat (5) tick();
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!ready && n < 40);
        check("glitch_latency", n, 11);
        check("glitch_tmo", timeout_count, 0);
        check("glitch_lost", lock_lost_count, 2);

        // WAIT_LOCK timeouts with the PLL never locking.
        pll_locked = 1'b0;
        wait_state(2'd1, 40, n);
        check("tmo_enter_wait", state, 1);
        n = 0;
        do begin
            tick();
            n++;
        end while (state == 2'd1 && n < 60);
        check("timeout_len", n, 32);
        check("timeout_count1", timeout_count, 1);
        check("timeout_pll_rst", pll_rst, 1);
        n = 0;
        do begin
            tick();
            n++;
        end while (pll_rst && n < 20);
        check("retry_pulse_len", n, 4);
        for (int i = 0; i < 2; i++) begin
            wait_state(2'd0, 60, n);
            wait_state(2'd1, 20, n);
        end
        check("timeout_count3", timeout_count, 3);
        check("lost_after_tmo", lock_lost_count, 3);

        // Stable completion on the last WAIT_LOCK cycle beats the timeout.
        repeat (21) tick();
        pll_locked = 1'b1;
        repeat (10) tick();
        check("coincide_not_yet", state, 1);
        tick();
        check("coincide_run", state, 2);
        check("coincide_tmo", timeout_count, 3);

        // Saturate the lock-loss counter.
        exp_lost = 3;
        for (int i = 0; i < 260; i++) begin
            pll_locked = 1'b0;
            wait_state(2'd0, 10, n);
            pll_locked = 1'b1;
            wait_ready(60, n);
            if (exp_lost < 255) exp_lost++;
            check("lost_count", lock_lost_count, exp_lost);
        end
        check("lost_saturated", lock_lost_count, 255);
        check("sat_tmo", timeout_count, 3);

        // Reset asserted mid-WAIT_LOCK.
        pll_locked = 1'b0;
        wait_state(2'd1, 20, n);
        check("midrst_enter_wait", state, 1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check_reset_values("midrst");
        rst        = 1'b0;
        pll_locked = 1'b1;
        wait_ready(40, n);
        check("post_rst_ready", ready, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pll_lock_sequencer.md
PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 SHALL have parameter RST_PULSE_CYCLES, default 16, meaning number of cycles pll_rst is held high per PLL reset attempt (minimum 1).
REQ-002 SHALL have parameter LOCK_STABLE_CYCLES, default 1024, meaning consecutive synchronized-lock cycles required before release (minimum 1).
REQ-003 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 65536, meaning maximum WAIT_LOCK cycles before a PLL reset retry; must exceed LOCK_STABLE_CYCLES.
REQ-004 SHALL have port refclk, input, 1, free-running reference clock; the only clock.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port pll_locked, input, 1, PLL lock indicator, asynchronous to refclk.
REQ-007 SHALL have port relock_req, input, 1, single-cycle software request to force a PLL re-lock.
REQ-008 SHALL have port pll_rst, output, 1, active-high reset to the PLL.
REQ-009 SHALL have port sys_reset, output, 1, active-high reset to downstream logic.
REQ-010 SHALL have port ready, output, 1, high while the PLL is locked and the system is released.
REQ-011 SHALL have port lock_lost_count, output, 8, saturating count of lock losses in RUN.
REQ-012 SHALL have port timeout_count, output, 8, saturating count of WAIT_LOCK timeouts.
REQ-013 SHALL have port state, output, 2, encoding 0=PLL_RESET, 1=WAIT_LOCK, 2=RUN.

Function
REQ-014 SHALL pass pll_locked through a 2-flop synchronizer into locked_s; no other logic samples pll_locked.
REQ-015 SHALL drive all outputs from registers with no combinational path from inputs.
REQ-016 PLL_RESET: pll_rst=1, sys_reset=1, ready=0; SHALL stay exactly RST_PULSE_CYCLES cycles, then go to WAIT_LOCK.
REQ-017 WAIT_LOCK: pll_rst=0, sys_reset=1, ready=0; stable counter increments on each locked_s=1 cycle and clears to 0 on any locked_s=0 cycle.
REQ-018 WAIT_LOCK SHALL go to RUN on the cycle the stable counter reaches LOCK_STABLE_CYCLES.
REQ-019 WAIT_LOCK SHALL go to PLL_RESET and increment timeout_count once LOCK_TIMEOUT_CYCLES cycles have elapsed in the state; if stable completion and timeout coincide, RUN wins and no increment occurs.
REQ-020 RUN: pll_rst=0, sys_reset=0, ready=1.
REQ-021 RUN SHALL go to PLL_RESET on locked_s=0 and increment lock_lost_count.
REQ-022 RUN SHALL go to PLL_RESET on relock_req=1 without incrementing any counter; if lock loss coincides, lock loss is counted once.
REQ-023 relock_req SHALL be ignored in PLL_RESET and WAIT_LOCK.
REQ-024 lock_lost_count and timeout_count SHALL saturate at 255 and never wrap.
REQ-025 Latency: with pll_locked held high from WAIT_LOCK entry, ready SHALL rise LOCK_STABLE_CYCLES+2 cycles after pll_locked is first sampled high.
REQ-026 Lock loss latency: ready=0 and sys_reset=1 SHALL occur no later than 3 cycles after pll_locked falls.
REQ-027 All internal counters SHALL be sized from the parameters; the cycle counter clears on every state entry.

Reset
REQ-028 While rst=1: state=PLL_RESET, pll_rst=1, sys_reset=1, ready=0, both counts=0, synchronizer flops=0, internal counters=0.
REQ-029 After rst deasserts, pll_rst SHALL remain high for exactly RST_PULSE_CYCLES further cycles.
REQ-030 rst asserted in any state SHALL take effect on the next refclk edge; an in-progress sequence is abandoned.

Verification (RST_PULSE_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32)
REQ-031 Release rst, then hold pll_locked=1 -> pll_rst high 4 cycles; ready=1 and sys_reset=0 exactly 10 cycles after the first high sample; counts=0.
REQ-032 Keep pll_locked=0 -> 32 WAIT_LOCK cycles, then a 4-cycle pll_rst pulse with timeout_count=1; after 3 retries timeout_count=3.
REQ-033 In WAIT_LOCK, pulse pll_locked low 1 cycle after 5 stable cycles -> stable count restarts; ready is delayed by the glitch plus 5 cycles; no timeout occurs.
REQ-034 In RUN, drop pll_locked -> within 3 cycles ready=0, sys_reset=1, state=0, lock_lost_count=1; re-lock then returns to RUN.
REQ-035 In RUN, pulse relock_req -> state=0 next cycle, pll_rst 4 cycles, lock_lost_count unchanged; relock_req pulsed in WAIT_LOCK has no effect.
REQ-036 Force 260 lock losses -> lock_lost_count=255; assert rst mid-WAIT_LOCK -> all outputs return to their reset values on the next edge.
